// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache. Hits answer combinationally;
// a miss stalls fetch while the whole line is refilled one word per handshake.
module icache_dm #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic [31:0] f_instr,
    output logic        f_valid,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int WO = $clog2(WORDS);
    localparam int IX = $clog2(LINES);
    localparam int TW = 32 - 2 - WO - IX;
    localparam int BW = 32 - 2 - WO;

    typedef enum logic {IDLE, FILL} state_t;

    state_t           state_q, state_d;
    logic [LINES-1:0] valid_q;
    logic [TW-1:0]    tag_mem  [LINES];
    logic [31:0]      data_mem [LINES*WORDS];

    logic [BW-1:0]    base_q, base_d;
    logic [WO-1:0]    cnt_q, cnt_d, cnt_inc;
    logic             flush_pend_q, flush_pend_d;
    logic             mem_req_d;
    logic [31:0]      mem_addr_d;
    logic             fill_we, fill_last;

    logic [WO-1:0]    f_wo;
    logic [IX-1:0]    f_idx, fill_idx;
    logic [TW-1:0]    f_tag, fill_tag;
    logic             hit;
    logic             unused_addr_bits;

    // base_q holds the line number; its low IX bits are the index, the rest the tag
    assign f_wo     = f_addr[2+WO-1:2];
    assign f_idx    = f_addr[2+WO+IX-1:2+WO];
    assign f_tag    = f_addr[31:2+WO+IX];
    assign fill_idx = base_q[IX-1:0];
    assign fill_tag = base_q[BW-1:IX];
    assign cnt_inc  = cnt_q + 1'b1;
    assign unused_addr_bits = ^f_addr[1:0];

    assign hit     = valid_q[f_idx] && (tag_mem[f_idx] == f_tag);
    assign f_valid = (state_q == IDLE) && f_req && hit && !flush;
    assign f_instr = data_mem[{f_idx, f_wo}];

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        mem_req_d    = mem_req;
        mem_addr_d   = mem_addr;
        fill_we      = 1'b0;
        fill_last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                flush_pend_d = 1'b0;
                if (f_req && !hit) begin
                    state_d    = FILL;
                    base_d     = f_addr[31:2+WO];
                    cnt_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {f_addr[31:2+WO], {WO{1'b0}}, 2'b00};
                end
            end
            FILL: begin
                if (flush) flush_pend_d = 1'b1;
                if (mem_ack) begin
                    fill_we    = 1'b1;
                    cnt_d      = cnt_inc;
                    mem_addr_d = {base_q, cnt_inc, 2'b00};
                    if (cnt_q == WO'(WORDS - 1)) begin
                        fill_last    = 1'b1;
                        state_d      = IDLE;
                        mem_req_d    = 1'b0;
                        flush_pend_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            base_q       <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            mem_req      <= mem_req_d;
            mem_addr     <= mem_addr_d;
        end
    end

    // A flush on the final ack cycle must also keep the new line invalid
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (flush) valid_q <= '0;
            if (fill_last && !flush_pend_q && !flush) valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we)   data_mem[{fill_idx, cnt_q}] <= mem_rdata;
        if (fill_last) tag_mem[fill_idx]           <= fill_tag;
    end
endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: directed scenarios plus randomized traffic, checked
// every cycle against a line-level model of what the cache must hold.
module tb_icache_dm;
    localparam int LINES = 16;
    localparam int WORDS = 4;

    logic        clk;
    logic        rst;
    logic        f_req;
    logic [31:0] f_addr;
    logic [31:0] f_instr;
    logic        f_valid;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    icache_dm #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .f_req(f_req), .f_addr(f_addr),
        .f_instr(f_instr), .f_valid(f_valid), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int ack_mode = 0;
    int wait_cnt = 0;

    // Backing memory contents are a fixed function of the word address
    function automatic logic [31:0] mem_func(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        return 32'hA0 + (w >> 2) + (w & 32'hFFFF_FF00) * 3;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Model: which memory line each cache slot holds, and the fill in flight
    bit          m_ready = 1'b0;
    bit          m_busy;
    logic [27:0] m_base;
    int          m_k;
    bit          m_flushseen;
    bit          m_addr_zero;
    bit          m_valid [LINES];
    logic [27:0] m_line  [LINES];
    bit          m_h;
    bit          exp_valid;

    function automatic bit m_hit(input logic [31:0] a);
        int slot;
        slot = int'(a[31:4] % LINES);
        return m_valid[slot] && (m_line[slot] == a[31:4]);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ready = 1'b1;
            m_busy = 1'b0;
            m_k = 0;
            m_flushseen = 1'b0;
            m_addr_zero = 1'b1;
            foreach (m_valid[i]) m_valid[i] = 1'b0;
        end else if (m_ready) begin
            if (!m_busy) begin
                m_h = m_hit(f_addr);
                if (flush) foreach (m_valid[i]) m_valid[i] = 1'b0;
                if (f_req && !m_h) begin
                    m_busy = 1'b1;
                    m_base = f_addr[31:4];
                    m_k = 0;
                    m_flushseen = 1'b0;
                    m_addr_zero = 1'b0;
                end
            end else begin
                if (flush) begin
                    foreach (m_valid[i]) m_valid[i] = 1'b0;
                    m_flushseen = 1'b1;
                end
                if (mem_ack) begin
                    m_k++;
                    if (m_k == WORDS) begin
                        m_line[int'(m_base % LINES)]  = m_base;
                        m_valid[int'(m_base % LINES)] = !m_flushseen;
                        m_busy = 1'b0;
                        m_k = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            exp_valid = !m_busy && f_req && m_hit(f_addr) && !flush;
            checkOutput("f_valid", 32'(f_valid), 32'(exp_valid));
            if (exp_valid) checkOutput("f_instr", f_instr, mem_func(f_addr));
            checkOutput("mem_req", 32'(mem_req), 32'(m_busy));
            if (m_busy)
                checkOutput("mem_addr", mem_addr, {m_base, 4'b0000} + 32'(4 * m_k));
            else if (m_addr_zero)
                checkOutput("mem_addr_rst", mem_addr, 32'h0);
        end
    end

    task automatic applyStimulus(input bit r, input bit req, input logic [31:0] a,
                                 input bit fl);
        @(posedge clk);
        #1;
        rst = r;
        f_req = req;
        f_addr = a;
        flush = fl;
        case (ack_mode)
            0: mem_ack = mem_req;
            1: mem_ack = ($urandom_range(0, 2) == 0);
            default: begin
                if (mem_req) begin
                    if (wait_cnt == 3) begin
                        mem_ack = 1'b1;
                        wait_cnt = 0;
                    end else begin
                        mem_ack = 1'b0;
                        wait_cnt++;
                    end
                end else begin
                    mem_ack = 1'b0;
                    wait_cnt = 0;
                end
            end
        endcase
        mem_rdata = mem_func(mem_addr);
        @(negedge clk);
    endtask

    task automatic finishFill(input logic [31:0] a, output int n);
        n = 0;
        do begin
            applyStimulus(1'b0, 1'b1, a, 1'b0);
            n++;
        end while (mem_req === 1'b1 && n < 200);
        if (n >= 200) checkOutput("fill_timeout", 32'(n), 32'(0));
    endtask

    task automatic fillWait(input logic [31:0] a, output int n);
        applyStimulus(1'b0, 1'b1, a, 1'b0);
        finishFill(a, n);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [31:0] a;
        rst = 1'b1; f_req = 1'b0; f_addr = '0; flush = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;

        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("reset_f_valid", 32'(f_valid), 32'(0));
        checkOutput("reset_mem_req", 32'(mem_req), 32'(0));
        checkOutput("reset_mem_addr", mem_addr, 32'h0);

        // cold miss with single-cycle acks
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0);
        checkOutput("cold_stall", 32'(f_valid), 32'(0));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h0, 1'b0);
            checkOutput("cold_req", 32'(mem_req), 32'(1));
            checkOutput("cold_addr", mem_addr, 32'(i * 4));
        end
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0);
        checkOutput("cold_hit_valid", 32'(f_valid), 32'(1));
        checkOutput("cold_hit_instr", f_instr, 32'hA0);

        applyStimulus(1'b0, 1'b1, 32'h8, 1'b0);
        checkOutput("hit_valid", 32'(f_valid), 32'(1));
        checkOutput("hit_instr", f_instr, 32'hA2);
        checkOutput("hit_no_req", 32'(mem_req), 32'(0));

        // conflict on index 0, then back to tag 0
        fillWait(32'h100, n);
        checkOutput("conflict_penalty", 32'(n), 32'(WORDS + 1));
        checkOutput("conflict_instr", f_instr, 32'h3E0);
        applyStimulus(1'b0, 1'b1, 32'h10C, 1'b0);
        checkOutput("conflict_word3", f_instr, 32'h3E3);
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0);
        checkOutput("conflict_evicted", 32'(f_valid), 32'(0));
        finishFill(32'h0, n);
        checkOutput("refill_instr", f_instr, 32'hA0);

        // stretched ack: three wait cycles per word
        ack_mode = 2;
        fillWait(32'h240, n);
        checkOutput("stretch_penalty", 32'(n), 32'(17));
        applyStimulus(1'b0, 1'b1, 32'h248, 1'b0);
        checkOutput("stretch_instr", f_instr, 32'h732);
        ack_mode = 0;

        // flush while the third word is outstanding
        applyStimulus(1'b0, 1'b1, 32'h310, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h310, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h310, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h310, 1'b1);
        checkOutput("flush_fill_req", 32'(mem_req), 32'(1));
        checkOutput("flush_fill_addr", mem_addr, 32'h318);
        finishFill(32'h310, n);
        checkOutput("flush_fill_done", 32'(mem_req), 32'(0));
        checkOutput("flush_fill_miss", 32'(f_valid), 32'(0));
        finishFill(32'h310, n);
        checkOutput("flush_refetch", f_instr, 32'hA64);
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0);
        checkOutput("flush_other_line", 32'(f_valid), 32'(0));
        finishFill(32'h0, n);

        // flush in idle turns a hit into a miss
        applyStimulus(1'b0, 1'b1, 32'h314, 1'b0);
        checkOutput("idle_pre_hit", 32'(f_valid), 32'(1));
        applyStimulus(1'b0, 1'b1, 32'h314, 1'b1);
        checkOutput("idle_flush_cycle", 32'(f_valid), 32'(0));
        applyStimulus(1'b0, 1'b1, 32'h314, 1'b0);
        checkOutput("idle_flush_after", 32'(f_valid), 32'(0));
        finishFill(32'h314, n);

        // reset in the middle of a fill
        applyStimulus(1'b0, 1'b1, 32'h400, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h400, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h400, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h400, 1'b0);
        checkOutput("midfill_rst_req", 32'(mem_req), 32'(0));
        applyStimulus(1'b0, 1'b1, 32'h400, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h400, 1'b0);
        checkOutput("midfill_restart", mem_addr, 32'h400);
        finishFill(32'h400, n);
        checkOutput("midfill_instr", f_instr, 32'hDA0);
        applyStimulus(1'b0, 1'b1, 32'h314, 1'b0);
        checkOutput("midfill_old_line", 32'(f_valid), 32'(0));
        finishFill(32'h314, n);

        // randomized traffic over a small address pool to get hits and conflicts
        ack_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4)
              | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            applyStimulus($urandom_range(0, 399) == 0, $urandom_range(0, 4) != 0, a,
                          $urandom_range(0, 39) == 0);
        end
        ack_mode = 0;
        repeat (8) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
